// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with programmable taps/seed,
// valid/ready output, zero-state recovery and sequence-period measurement.
module lfsr_gen #(
    parameter int              WIDTH        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(8'h01)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] seedIn,
    input  logic             seedLoad,
    input  logic [WIDTH-1:0] tapIn,
    input  logic             tapEn,
    input  logic             mode,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             outValid,
    output logic             bitOut,
    output logic             lockup,
    output logic [WIDTH-1:0] period,
    output logic             periodValid
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_fsm;
    logic [WIDTH-1:0] r_state, r_taps, r_ref, r_cnt, r_period;
    logic             r_valid, r_lockup, r_pvalid;
    logic             w_step, w_fb, w_msb, w_cap;
    logic [WIDTH-1:0] w_fib, w_gal, w_calc, w_next, w_seed;

    assign w_step = (r_fsm == RUN) & r_valid & outReady & !seedLoad;
    assign w_fb   = ^(r_state & r_taps);
    assign w_fib  = {r_state[WIDTH-2:0], w_fb};
    assign w_msb  = r_state[WIDTH-1];
    assign w_gal  = {r_state[WIDTH-2:0], w_msb} ^ ({WIDTH{w_msb}} & {r_taps[WIDTH-1:1], 1'b0});
    assign w_calc = mode ? w_gal : w_fib;
    assign w_next = (w_calc == '0) ? DEFAULT_SEED : w_calc;
    assign w_seed = (seedIn == '0) ? DEFAULT_SEED : seedIn;
    // A saturated counter can no longer yield a trustworthy period, so never capture then.
    assign w_cap  = (w_next == r_ref) & !r_pvalid & !(&r_cnt);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_fsm    <= IDLE;
            r_state  <= '0;
            r_valid  <= 1'b0;
            r_taps   <= DEFAULT_TAPS;
            r_ref    <= '0;
            r_cnt    <= '0;
            r_period <= '0;
            r_pvalid <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= 1'b0;
            if (tapEn) r_taps <= tapIn;
            if (seedLoad) begin
                r_fsm    <= RUN;
                r_valid  <= 1'b1;
                r_state  <= w_seed;
                r_ref    <= w_seed;
                r_lockup <= (seedIn == '0);
                r_cnt    <= '0;
                r_pvalid <= 1'b0;
            end else if (w_step) begin
                r_state  <= w_next;
                r_lockup <= (w_calc == '0);
                r_cnt    <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                if (w_cap) begin
                    r_period <= r_cnt + 1'b1;
                    r_pvalid <= 1'b1;
                end
            end
        end
    end

    assign out         = r_state;
    assign outValid    = r_valid;
    assign bitOut      = r_state[WIDTH-1];
    assign lockup      = r_lockup;
    assign period      = r_period;
    assign periodValid = r_pvalid;
endmodule
